// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states, default bus address, bus ACK/NACK levels.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_REG,
        ST_REG_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK
    } i2c_tgt_state_t;

    localparam logic [6:0] I2C_TGT_ADDR_DEFAULT = 7'h50;

    // SDA level seen on the ninth clock of a byte.
    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// I2C bus front end: 2-FF synchronizers on SCL/SDA, registered SCL rise/fall
// pulses and START/STOP pulses. A raw pin change shows up as a pulse three
// clk cycles later; sda_smp is the synchronized SDA level aligned with the pulses.
module i2c_bus_sync (
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_smp
);

    logic [1:0] scl_sync_q;
    logic [1:0] sda_sync_q;
    logic       scl_prev_q;
    logic       sda_prev_q;
    logic       scl_rise_q;
    logic       scl_fall_q;
    logic       start_q;
    logic       stop_q;
    logic       sda_smp_q;

    // Synchronize the raw pins and derive registered edge/condition pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            sda_smp_q  <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_in};
            sda_sync_q <= {sda_sync_q[0], sda_in};
            scl_prev_q <= scl_sync_q[1];
            sda_prev_q <= sda_sync_q[1];
            scl_rise_q <= scl_sync_q[1] & ~scl_prev_q;
            scl_fall_q <= ~scl_sync_q[1] & scl_prev_q;
            // SDA moving while SCL stays high is a bus condition, not data.
            start_q    <= scl_sync_q[1] & scl_prev_q & sda_prev_q & ~sda_sync_q[1];
            stop_q     <= scl_sync_q[1] & scl_prev_q & ~sda_prev_q & sda_sync_q[1];
            sda_smp_q  <= sda_sync_q[1];
        end
    end

    assign scl_rise  = scl_rise_q;
    assign scl_fall  = scl_fall_q;
    assign start_det = start_q;
    assign stop_det  = stop_q;
    assign sda_smp   = sda_smp_q;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with a byte-wide register file, pointer-addressed reads/writes,
// a host-side write port and a bus-write notification strobe.
// Optional feature macro I2C_TGT_AUTOINC_EN: when defined the register pointer
// advances after each written byte and each master-ACKed read byte; otherwise
// it stays fixed for the whole transaction.
module i2c_target_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0] TGT_ADDR = I2C_TGT_ADDR_DEFAULT,
    parameter int         NREGS    = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     scl_in,
    input  logic                     sda_in,
    output logic                     sda_oe,
    output logic                     busy,
    output logic                     wr_strobe,
    output logic [$clog2(NREGS)-1:0] wr_addr,
    output logic [7:0]               wr_data,
    input  logic                     host_we,
    input  logic [$clog2(NREGS)-1:0] host_waddr,
    input  logic [7:0]               host_wdata
);

    localparam int PW = $clog2(NREGS);

    logic scl_rise, scl_fall, start_det, stop_det, sda_smp;

    i2c_bus_sync u_sync (
        .clk       (clk),
        .reset     (reset),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_smp   (sda_smp)
    );

    i2c_tgt_state_t  state_q, state_d;
    logic [2:0]      bitcnt_q, bitcnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [7:0]      tx_q, tx_d;
    logic            rw_q, rw_d;
    logic            sda_oe_q, sda_oe_d;
    logic            busy_q, busy_d;
    logic [7:0]      regs_q [NREGS];
    logic            wr_strobe_q;
    logic [PW-1:0]   wr_addr_q;
    logic [7:0]      wr_data_q;

    logic            bus_we;
    logic [7:0]      byte_in;
    logic            last_bit;
    logic [PW-1:0]   ptr_adv;

    assign byte_in  = {shift_q[6:0], sda_smp};
    assign last_bit = (bitcnt_q == 3'd7);

`ifdef I2C_TGT_AUTOINC_EN
    assign ptr_adv = ptr_q + PW'(1);
`else
    assign ptr_adv = ptr_q;
`endif

    // Next-state logic: STOP beats START beats SCL edges; SDA is only ever
    // changed on a detected SCL falling edge so it is stable while SCL is high.
    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        ptr_d    = ptr_q;
        tx_d     = tx_q;
        rw_d     = rw_q;
        sda_oe_d = sda_oe_q;
        busy_d   = busy_q;
        bus_we   = 1'b0;

        if (stop_det) begin
            state_d  = ST_IDLE;
            bitcnt_d = 3'd0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start_det) begin
            // Repeated START keeps the pointer so a read can follow a pointer write.
            state_d  = ST_ADDR;
            bitcnt_d = 3'd0;
            sda_oe_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    sda_oe_d = 1'b0;
                end
                ST_ADDR: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                    end else if (scl_rise) begin
                        shift_d  = byte_in;
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (last_bit) begin
                            if (byte_in[7:1] == TGT_ADDR) begin
                                state_d = ST_ADDR_ACK;
                                rw_d    = byte_in[0];
                                busy_d  = 1'b1;
                            end else begin
                                state_d = ST_IDLE;
                                busy_d  = 1'b0;
                            end
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = ~I2C_ACK;
                    end else if (scl_rise) begin
                        bitcnt_d = 3'd0;
                        if (rw_q) begin
                            state_d = ST_RDATA;
                            tx_d    = regs_q[ptr_q];
                        end else begin
                            state_d = ST_REG;
                        end
                    end
                end
                ST_REG: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                    end else if (scl_rise) begin
                        shift_d  = byte_in;
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (last_bit) begin
                            if ({1'b0, byte_in} < 9'(NREGS)) begin
                                state_d = ST_REG_ACK;
                                ptr_d   = byte_in[PW-1:0];
                            end else begin
                                // Out-of-range pointer: leave SDA released so the master sees NACK.
                                state_d = ST_IDLE;
                                busy_d  = 1'b0;
                            end
                        end
                    end
                end
                ST_REG_ACK, ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = ~I2C_ACK;
                    end else if (scl_rise) begin
                        state_d  = ST_WDATA;
                        bitcnt_d = 3'd0;
                    end
                end
                ST_WDATA: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                    end else if (scl_rise) begin
                        shift_d  = byte_in;
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (last_bit) begin
                            bus_we  = 1'b1;
                            ptr_d   = ptr_adv;
                            state_d = ST_WDATA_ACK;
                        end
                    end
                end
                ST_RDATA: begin
                    // The first falling edge here also releases the preceding ACK.
                    if (scl_fall) begin
                        sda_oe_d = ~tx_q[7];
                        tx_d     = {tx_q[6:0], 1'b0};
                    end else if (scl_rise) begin
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (last_bit) begin
                            state_d = ST_RDATA_ACK;
                        end
                    end
                end
                ST_RDATA_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                    end else if (scl_rise) begin
                        bitcnt_d = 3'd0;
                        if (sda_smp == I2C_ACK) begin
                            ptr_d   = ptr_adv;
                            tx_d    = regs_q[ptr_adv];
                            state_d = ST_RDATA;
                        end else begin
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    sda_oe_d = 1'b0;
                    busy_d   = 1'b0;
                end
            endcase
        end
    end

    // Protocol state registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            bitcnt_q <= 3'd0;
            shift_q  <= 8'h00;
            ptr_q    <= '0;
            tx_q     <= 8'h00;
            rw_q     <= 1'b0;
            sda_oe_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            ptr_q    <= ptr_d;
            tx_q     <= tx_d;
            rw_q     <= rw_d;
            sda_oe_q <= sda_oe_d;
            busy_q   <= busy_d;
        end
    end

    // Register file: the bus write is applied last so it wins a same-register collision.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            if (host_we) begin
                regs_q[host_waddr] <= host_wdata;
            end
            if (bus_we) begin
                regs_q[ptr_q] <= byte_in;
            end
        end
    end

    // Write notification, coincident with the register update becoming visible.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= 8'h00;
        end else begin
            wr_strobe_q <= bus_we;
            if (bus_we) begin
                wr_addr_q <= ptr_q;
                wr_data_q <= byte_in;
            end
        end
    end

    assign sda_oe    = sda_oe_q;
    assign busy      = busy_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;

endmodule

// File: doc/i2c_target_regs.md
# i2c_target_regs

I2C target (slave) with an internal byte-wide register file, sitting on the far side of the bus from the team's I2C master and answering its address/register/data transactions. Oversamples SCL/SDA on the system clock, detects START/STOP, ACKs its own address, accepts register-pointer and write-data bytes, and returns read data with pointer auto-increment. Exposes a host-side write port and a write-notification strobe to the local logic.

## Interface
- `TGT_ADDR`, 7'h50: 7-bit bus address this target answers.
- `NREGS`, 16: register count; power of two, 2..256.
- `clk` in 1: system clock; must run ≥ 10x SCL frequency.
- `reset` in 1: synchronous, active-low reset.
- `scl_in` in 1: raw bus SCL (asynchronous).
- `sda_in` in 1: raw bus SDA (asynchronous).
- `sda_oe` out 1: 1 = pull SDA low, 0 = release.
- `busy` out 1: high from an address-matched START until STOP/NACK/mismatch.
- `wr_strobe` out 1: one-cycle pulse when a bus write commits to the register file.
- `wr_addr` out $clog2(NREGS): register written, valid with `wr_strobe`.
- `wr_data` out 8: byte written, valid with `wr_strobe`.
- `host_we` in 1: host write enable.
- `host_waddr` in $clog2(NREGS): host write register index.
- `host_wdata` in 8: host write data.

## Operation
- `scl_in`/`sda_in` pass through a 2-FF synchronizer; edge and START/STOP detection use the synchronized values.
- START: SDA falls while SCL high. STOP: SDA rises while SCL high.
- States: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
- IDLE → ADDR on START. ADDR shifts 8 bits MSB-first on SCL rising edges (7 address bits + R/W).
- Address match → ADDR_ACK (drive ACK), `busy`=1; R/W=0 → REG, R/W=1 → RDATA. Mismatch → IDLE, no ACK.
- REG: 8 bits into the pointer. Byte < NREGS → ACK, pointer loaded, → WDATA. Byte ≥ NREGS → NACK, → IDLE.
- WDATA: 8 bits; on 8th rising edge commit to `regs[ptr]`, pulse `wr_strobe`, ACK, then pointer advance (see Configuration); → WDATA for the next byte.
- RDATA: load `regs[ptr]` at entry; drive bits MSB-first (`sda_oe` = ~bit). RDATA_ACK: release SDA, sample master bit on SCL rising: 0 → advance pointer, RDATA; 1 (NACK) → IDLE.
- Repeated START in any state → ADDR, bit counter cleared, pointer retained.
- STOP in any state → IDLE, `sda_oe`=0, `busy`=0.
- Pointer wraps NREGS-1 → 0.
- Same-cycle bus commit and host write to the same register: bus write wins; different registers: both commit.

## Timing
- Reset (`reset`=0 at a `clk` edge): state IDLE, all registers 8'h00, pointer 0, `sda_oe`=0, `busy`=0, `wr_strobe`=0, `wr_addr`=0, `wr_data`=0. Reset mid-transfer releases SDA on the next cycle; the target then waits for a fresh START.
- Bus-to-detect latency: 3 `clk` cycles from a raw pin change to the edge/START/STOP pulse.
- SDA sampled on detected SCL rising edge; `sda_oe` changes only in the cycle after a detected SCL falling edge (never while SCL high).
- ACK: asserted after the falling edge ending bit 8, released after the next falling edge.
- `wr_strobe` asserted the cycle after the 8th data rising edge; register visible the same cycle.
- Host write visible the cycle after `host_we`.
- Read byte latched at RDATA entry; a host write during the byte affects the next read only.

## Configuration
- `I2C_TGT_AUTOINC_EN` defined: pointer increments (mod NREGS) after each written byte and after each master-ACKed read byte.
- Undefined: pointer stays fixed for the whole transaction; burst writes overwrite one register, burst reads repeat it.

## Structure
- Package `i2c_pkg`: state enum `i2c_tgt_state_t`, default target address constant, ACK/NACK level constants; shared with the master.
- Sub-module `i2c_bus_sync`: 2-FF synchronizers, SCL rise/fall pulses, START/STOP pulses.

## Test plan
- Write 0x50/W, reg 0x03, data 0xA5, STOP → three ACKs, `wr_strobe` once with `wr_addr`=3, `wr_data`=0xA5, regs[3]=0xA5.
- Address 0x51 → no ACK (`sda_oe` stays 0), `busy` stays 0, no register change.
- Write reg 0x0F data 0x11,0x22 (AUTOINC on) → regs[15]=0x11, regs[0]=0x22 (wrap); AUTOINC off → regs[15]=0x22.
- Write reg 0x02, repeated START, 0x50/R, read two bytes ACK then NACK → returns regs[2], regs[3]; IDLE after NACK.
- Reg byte 0x20 with NREGS=16 → NACK on 9th clock, return to IDLE, no strobe.
- `reset` low mid-data-byte → `sda_oe`=0 next cycle, all regs 0x00; next transaction from START works normally.
